// File: rtl/and_op_seq_pkg.sv
// Shared types and constants for the and_op_seq operation sequencer.
package and_op_pkg;

    localparam int N_REQ_MAX = 8;
    localparam int IDX_W     = $clog2(N_REQ_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Advance a requester index by one, wrapping at the live requester count.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
        if (int'(idx) + 1 >= n) return '0;
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/and_op_seq_if.sv
// Requester and shared-AND-unit signal bundle for and_op_seq.
interface and_op_seq_if #(parameter int N_REQ = 4);

    logic [N_REQ-1:0] pi_req;
    logic [N_REQ-1:0] pi_a;
    logic [N_REQ-1:0] pi_b;
    logic [N_REQ-1:0] po_ack;
    logic             po_c;
    logic             po_flag;
    logic             po_a;
    logic             po_b;
    logic             pi_c;

    // The environment side: requesters plus the AND unit.
    modport master (
        output pi_req, pi_a, pi_b, pi_c,
        input  po_ack, po_c, po_flag, po_a, po_b
    );

    modport slave (
        input  pi_req, pi_a, pi_b, pi_c,
        output po_ack, po_c, po_flag, po_a, po_b
    );

endinterface

// File: rtl/and_op_seq_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after rr_ptr, wrapping.
module rr_arbiter
    import and_op_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index
);

    logic found;

    // First pass covers rr_ptr..N_REQ-1, second pass wraps to 0..rr_ptr-1.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i >= int'(rr_ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                index    = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                index    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/and_op_seq.sv
// Sequences requester operations through one shared registered AND unit.
// Define AND_OP_SEQ_STAT_EN to add the po_op_cnt completed-operation counter.
module and_op_seq
    import and_op_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic         clk,
    input  logic         rst,
    and_op_seq_if.slave  bus
`ifdef AND_OP_SEQ_STAT_EN
    ,
    output logic [15:0]  po_op_cnt
`endif
);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_oh;
    logic             op_a;
    logic             op_b;
    logic             result;
    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_index;
    logic             any_req;

    assign any_req = |bus.pi_req;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (bus.pi_req),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .index  (arb_index)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured at grant so later requester changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            grant_oh  <= '0;
            op_a      <= 1'b0;
            op_b      <= 1'b0;
            result    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_oh  <= arb_grant;
                        grant_idx <= arb_index;
                        op_a      <= |(bus.pi_a & arb_grant);
                        op_b      <= |(bus.pi_b & arb_grant);
                    end
                end
                WAIT:    result <= bus.pi_c;
                RESP:    rr_ptr <= wrap_inc(grant_idx, N_REQ);
                default: ;
            endcase
        end
    end

    assign bus.po_flag = (state == ISSUE);
    assign bus.po_a    = bus.po_flag & op_a;
    assign bus.po_b    = bus.po_flag & op_b;
    assign bus.po_ack  = (state == RESP) ? grant_oh : '0;
    assign bus.po_c    = (state == RESP) & result;

`ifdef AND_OP_SEQ_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) po_op_cnt <= '0;
        else if (state == RESP) po_op_cnt <= po_op_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_and_op_seq.sv
// Scoreboard bench for and_op_seq with a behavioural registered AND unit.
// Also checks po_op_cnt when AND_OP_SEQ_STAT_EN is defined.
module tb_and_op_seq;

    localparam int N = 4;

    typedef struct {
        int   idx;
        logic c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    int   respCount  = 0;
    exp_t expQ[$];

    and_op_seq_if #(.N_REQ(N)) bus ();

`ifdef AND_OP_SEQ_STAT_EN
    logic [15:0] opCnt;
    and_op_seq #(.N_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus), .po_op_cnt(opCnt));
`else
    and_op_seq #(.N_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Shared AND unit: result appears one cycle after the enable strobe.
    always @(posedge clk) bus.pi_c <= bus.po_flag ? (bus.po_a & bus.po_b) : 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExpect(input int idx, input logic c);
        exp_t e;
        e.idx = idx;
        e.c   = c;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.pi_req = req;
        bus.pi_a   = a;
        bus.pi_b   = b;
    endtask

    task automatic waitAck(input bit clearOnAck, output int cycles, output logic [N-1:0] ackSeen);
        cycles  = 0;
        ackSeen = '0;
        while (cycles < 20 && ackSeen == '0) begin
            @(negedge clk);
            cycles++;
            ackSeen = bus.po_ack;
        end
        if (ackSeen == '0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ack_timeout: got no ack, expected one within 20 cycles at %0t", $time);
        end
        if (clearOnAck) bus.pi_req = bus.pi_req & ~ackSeen;
    endtask

    // Monitor: pops the scoreboard on every ack and polices idle outputs.
    always @(negedge clk) begin
        exp_t e;
        if (rst) respCount = 0;
        if (!bus.po_flag) begin
            checkOutput("a_outside_issue", 32'(bus.po_a), 32'd0);
            checkOutput("b_outside_issue", 32'(bus.po_b), 32'd0);
        end
        if (bus.po_ack == '0) begin
            checkOutput("c_without_ack", 32'(bus.po_c), 32'd0);
        end else begin
            respCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_ack", 32'(bus.po_ack), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("ack_index", 32'(bus.po_ack), 32'd1 << e.idx);
                checkOutput("ack_result", 32'(bus.po_c), 32'(e.c));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        logic [N-1:0] ack;

        applyStimulus('0, '0, '0);
        repeat (3) @(negedge clk);
        checkOutput("reset_ack", 32'(bus.po_ack), 32'd0);
        checkOutput("reset_flag", 32'(bus.po_flag), 32'd0);
        checkOutput("reset_c", 32'(bus.po_c), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single request: flag one cycle after grant, ack two cycles later.
        applyStimulus(4'b0001, 4'b0001, 4'b0001);
        pushExpect(0, 1'b1);
        @(negedge clk);
        checkOutput("t1_issue_flag", 32'(bus.po_flag), 32'd1);
        checkOutput("t1_issue_a", 32'(bus.po_a), 32'd1);
        checkOutput("t1_issue_b", 32'(bus.po_b), 32'd1);
        @(negedge clk);
        checkOutput("t1_wait_flag", 32'(bus.po_flag), 32'd0);
        waitAck(1'b1, cycles, ack);
        checkOutput("t1_latency", 32'(cycles), 32'd1);
        repeat (3) @(negedge clk);

        // Result zero; operand A dropped after grant.
        applyStimulus(4'b0100, 4'b0100, 4'b0000);
        pushExpect(2, 1'b0);
        @(negedge clk);
        bus.pi_a = '0;
        waitAck(1'b1, cycles, ack);
        repeat (2) @(negedge clk);

        // rr_ptr is now 3: requester 3 first, then wrap to 0.
        applyStimulus(4'b1001, 4'b1001, 4'b1000);
        pushExpect(3, 1'b1);
        pushExpect(0, 1'b0);
        waitAck(1'b1, cycles, ack);
        checkOutput("wrap_first", 32'(ack), 32'h8);
        waitAck(1'b1, cycles, ack);
        checkOutput("wrap_second", 32'(ack), 32'h1);
        repeat (2) @(negedge clk);

        // Both operands cleared after grant; latched ones still give 1.
        applyStimulus(4'b0010, 4'b0010, 4'b0010);
        pushExpect(1, 1'b1);
        @(negedge clk);
        bus.pi_a = '0;
        bus.pi_b = '0;
        waitAck(1'b1, cycles, ack);
        repeat (3) @(negedge clk);

        // Fairness from a fresh reset with all requests held.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(4'b1111, 4'b1111, 4'b0101);
        pushExpect(0, 1'b1);
        pushExpect(1, 1'b0);
        pushExpect(2, 1'b1);
        pushExpect(3, 1'b0);
        pushExpect(0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            waitAck(1'b0, cycles, ack);
            if (k > 0) checkOutput("fair_spacing", 32'(cycles), 32'd4);
        end
        bus.pi_req = '0;
        repeat (3) @(negedge clk);

        // Reset during WAIT aborts the op and clears outputs at once.
        applyStimulus(4'b0001, 4'b0001, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_ack", 32'(bus.po_ack), 32'd0);
        checkOutput("rst_flag", 32'(bus.po_flag), 32'd0);
        checkOutput("rst_c", 32'(bus.po_c), 32'd0);
        checkOutput("rst_a", 32'(bus.po_a), 32'd0);
        checkOutput("rst_b", 32'(bus.po_b), 32'd0);
        bus.pi_req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(4'b1010, 4'b1010, 4'b1010);
        pushExpect(1, 1'b1);
        pushExpect(3, 1'b1);
        waitAck(1'b1, cycles, ack);
        checkOutput("post_rst_grant", 32'(ack), 32'h2);
        waitAck(1'b1, cycles, ack);
        checkOutput("post_rst_next", 32'(ack), 32'h8);

        repeat (6) @(negedge clk);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
`ifdef AND_OP_SEQ_STAT_EN
        checkOutput("op_cnt", 32'(opCnt), 32'(respCount));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/and_op_seq.md
AND_OP_SEQ -- requirements
Module: and_op_seq

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pi_req  input  N_REQ  per-requester operation request, level, held until acked.
REQ-005 SHALL have port pi_a  input  N_REQ  per-requester operand A.
REQ-006 SHALL have port pi_b  input  N_REQ  per-requester operand B.
REQ-007 SHALL have port po_ack  output  N_REQ  one-cycle completion pulse, one-hot or zero.
REQ-008 SHALL have port po_c  output  1  result; valid only while any po_ack bit is high, else 0.
REQ-009 SHALL have port po_flag  output  1  enable strobe to the shared AND unit.
REQ-010 SHALL have port po_a  output  1  operand A to the AND unit.
REQ-011 SHALL have port po_b  output  1  operand B to the AND unit.
REQ-012 SHALL have port pi_c  input  1  registered result from the AND unit, 1-cycle latency after po_flag.

Function
REQ-013 SHALL run a 4-state FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; no other transitions except reset.
REQ-014 IDLE: if any pi_req bit high, SHALL grant via round-robin from pointer rr_ptr, latch the winner's pi_a/pi_b and index, go to ISSUE; else stay.
REQ-015 ISSUE: SHALL drive po_flag=1, po_a/po_b = latched operands for exactly one cycle; go to WAIT.
REQ-016 WAIT: SHALL capture pi_c into result register at end of cycle; po_flag=0; go to RESP.
REQ-017 RESP: SHALL assert po_ack[grant]=1 and po_c=captured result for exactly one cycle; rr_ptr <= (grant+1) mod N_REQ; go to IDLE.
REQ-018 Latency: request sampled in IDLE at edge k SHALL produce po_ack at cycle k+3; throughput one op per 4 cycles.
REQ-019 Operands SHALL be latched at grant; changes on pi_a/pi_b after grant SHALL not affect the result.
REQ-020 Requester dropping pi_req after grant SHALL still receive po_ack (no abort).
REQ-021 Requester still asserting pi_req in the cycle after its ack SHALL be treated as a new request, arbitrated normally.
REQ-022 Round-robin SHALL search rr_ptr, rr_ptr+1, ... wrapping at N_REQ; no requester starved beyond N_REQ-1 intervening grants.
REQ-023 po_flag, po_a, po_b SHALL be 0 outside ISSUE.

Reset
REQ-024 rst=1 SHALL asynchronously force state=IDLE, rr_ptr=0, po_ack=0, po_c=0, po_flag=0, po_a=0, po_b=0, latched operands/result=0.
REQ-025 Reset mid-operation SHALL abort the op with no po_ack; first grant after release SHALL start search at index 0.

Configuration
REQ-026 With macro AND_OP_SEQ_STAT_EN defined, SHALL add output po_op_cnt (16 bits) counting RESP cycles, wrapping 0xFFFF->0, reset to 0.
REQ-027 Without AND_OP_SEQ_STAT_EN, port po_op_cnt and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-028 Shared package and_op_pkg SHALL hold FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3) and constant N_REQ_MAX=8.
REQ-029 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req vector, rr_ptr; output one-hot grant, index).

Verification
REQ-030 Single req: N_REQ=4, pi_req=0001, a=1, b=1 at edge k -> po_flag=1 at k+1, po_ack=0001, po_c=1 at k+3.
REQ-031 Result 0: pi_req=0100, a=1, b=0 -> po_ack=0100, po_c=0; pi_a changed to 0 after grant has no effect.
REQ-032 Fairness: pi_req=1111 held continuously -> ack order 0,1,2,3,0 at 4-cycle spacing.
REQ-033 Wrap: rr_ptr=3, pi_req=1001 -> grant 3 then 0.
REQ-034 Reset mid-op: rst=1 during WAIT -> no po_ack, all outputs 0 immediately; after release, pi_req=1010 -> grant 1.
REQ-035 With AND_OP_SEQ_STAT_EN: 65537 completed ops -> po_op_cnt=1.
